// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and address-decode helper for the register issue scoreboard.
package reg_scoreboard_pkg;

    localparam int ADDR_WID   = 4;
    localparam int NUM_OF_REG = 15;
    localparam int CNT_WID    = 2;

    localparam logic [ADDR_WID-1:0] RNONE   = 4'hF;
    localparam logic [CNT_WID-1:0]  CNT_MAX = {CNT_WID{1'b1}};

    typedef logic [ADDR_WID-1:0]   addr_t;
    typedef logic [CNT_WID-1:0]    cnt_t;
    typedef logic [NUM_OF_REG-1:0] reg_vec_t;

    // RNONE and any out-of-range index decode to an empty set, so they never count or block.
    function automatic reg_vec_t reg_onehot(input addr_t addr);
        reg_vec_t oh;
        oh = {NUM_OF_REG{1'b0}};
        if ((addr != RNONE) && (int'(addr) < NUM_OF_REG)) begin
            oh[addr] = 1'b1;
        end else begin
            oh = {NUM_OF_REG{1'b0}};
        end
        return oh;
    endfunction

endpackage

// File: rtl/reg_scoreboard_counter.sv
// Per-register in-flight write counter: +1 on issue, -1 per wb/kill, clamps at 0 on underflow.
module reg_pend_counter
    import reg_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec_wb,
    input  logic dec_kill,
    output cnt_t cnt,
    output logic nz,
    output logic sat,
    output logic underflow
);

    logic signed [CNT_WID:0]   delta_s;
    logic signed [CNT_WID+1:0] sum_s;
    cnt_t                      cnt_nxt_s;
    logic                      underflow_s;
    cnt_t                      cnt_r;
    logic                      nz_r;
    logic                      sat_r;

    // Net change in CNT_WID+1 bits, applied to the count with one bit of headroom each way.
    always_comb begin
        delta_s     = $signed({{CNT_WID{1'b0}}, inc})
                    - $signed({{CNT_WID{1'b0}}, dec_wb})
                    - $signed({{CNT_WID{1'b0}}, dec_kill});
        sum_s       = $signed({2'b00, cnt_r}) + {delta_s[CNT_WID], delta_s};
        underflow_s = 1'b0;
        if (sum_s[CNT_WID+1]) begin
            cnt_nxt_s   = {CNT_WID{1'b0}};
            underflow_s = 1'b1;
        end else if (sum_s[CNT_WID]) begin
            cnt_nxt_s   = CNT_MAX;
        end else begin
            cnt_nxt_s   = sum_s[CNT_WID-1:0];
        end
    end

    // Count plus pre-decoded flags, all updated at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_WID{1'b0}};
            nz_r  <= 1'b0;
            sat_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            nz_r  <= (cnt_nxt_s != {CNT_WID{1'b0}});
            sat_r <= (cnt_nxt_s == CNT_MAX);
        end
    end

    assign cnt       = cnt_r;
    assign nz        = nz_r;
    assign sat       = sat_r;
    assign underflow = underflow_s;

endmodule

// File: rtl/reg_scoreboard.sv
// Issue scheduler: holds decode while a source has a pending write or a destination counter is full.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [ADDR_WID-1:0]   srcA,
    input  logic [ADDR_WID-1:0]   srcB,
    input  logic [ADDR_WID-1:0]   destE,
    input  logic [ADDR_WID-1:0]   destM,
    input  logic                  wb_valid,
    input  logic [ADDR_WID-1:0]   wb_destE,
    input  logic [ADDR_WID-1:0]   wb_destM,
    input  logic                  kill_valid,
    input  logic [ADDR_WID-1:0]   kill_destE,
    input  logic [ADDR_WID-1:0]   kill_destM,
    output logic [NUM_OF_REG-1:0] pending_vec,
    output logic                  err
);

    reg_vec_t src_oh_s;
    reg_vec_t dst_oh_s;
    reg_vec_t inc_vec_s;
    reg_vec_t wb_vec_s;
    reg_vec_t kill_vec_s;
    reg_vec_t nz_vec_s;
    reg_vec_t sat_vec_s;
    reg_vec_t uf_vec_s;
    cnt_t     cnt_s [NUM_OF_REG];
    logic     ready_s;
    logic     err_r;

    // Readiness looks only at registered counters; same-cycle wb/kill never bypass into it.
    always_comb begin
        src_oh_s = reg_onehot(srcA) | reg_onehot(srcB);
        dst_oh_s = reg_onehot(destE) | reg_onehot(destM);
        ready_s  = ~|(src_oh_s & nz_vec_s) & ~|(dst_oh_s & sat_vec_s);
        if (issue_valid && ready_s) begin
            inc_vec_s = dst_oh_s;
        end else begin
            inc_vec_s = {NUM_OF_REG{1'b0}};
        end
        if (wb_valid) begin
            wb_vec_s = reg_onehot(wb_destE) | reg_onehot(wb_destM);
        end else begin
            wb_vec_s = {NUM_OF_REG{1'b0}};
        end
        if (kill_valid) begin
            kill_vec_s = reg_onehot(kill_destE) | reg_onehot(kill_destM);
        end else begin
            kill_vec_s = {NUM_OF_REG{1'b0}};
        end
    end

    for (genvar r = 0; r < NUM_OF_REG; r++) begin : g_cnt
        reg_pend_counter u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc_vec_s[r]),
            .dec_wb    (wb_vec_s[r]),
            .dec_kill  (kill_vec_s[r]),
            .cnt       (cnt_s[r]),
            .nz        (nz_vec_s[r]),
            .sat       (sat_vec_s[r]),
            .underflow (uf_vec_s[r])
        );
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | (|uf_vec_s);
        end
    end

    assign issue_ready = ready_s;
    assign pending_vec = nz_vec_s;
    assign err         = err_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scenarios plus random traffic checked against a per-register count model.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [3:0]  srcA = 4'hF, srcB = 4'hF, destE = 4'hF, destM = 4'hF;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_destE = 4'hF, wb_destM = 4'hF;
    logic        kill_valid = 1'b0;
    logic [3:0]  kill_destE = 4'hF, kill_destM = 4'hF;
    logic [14:0] pending_vec;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_m [15];
    bit err_m = 1'b0;

    reg_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .srcA(srcA), .srcB(srcB), .destE(destE), .destM(destM),
        .wb_valid(wb_valid), .wb_destE(wb_destE), .wb_destM(wb_destM),
        .kill_valid(kill_valid), .kill_destE(kill_destE), .kill_destM(kill_destM),
        .pending_vec(pending_vec), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hits(input int r, input logic [3:0] a, input logic [3:0] b);
        return (int'(a) == r) || (int'(b) == r);
    endfunction

    function automatic bit m_ready();
        bit ok = 1'b1;
        if (srcA < 4'd15 && cnt_m[srcA] != 0) ok = 1'b0;
        if (srcB < 4'd15 && cnt_m[srcB] != 0) ok = 1'b0;
        if (destE < 4'd15 && cnt_m[destE] == 3) ok = 1'b0;
        if (destM < 4'd15 && cnt_m[destM] == 3) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [14:0] m_vec();
        logic [14:0] v = 15'h0000;
        for (int r = 0; r < 15; r++) v[r] = (cnt_m[r] != 0);
        return v;
    endfunction

    // One cycle: drive at negedge, check ready, then advance the model across the edge.
    task automatic step(input string tag,
                        input logic iv, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] e, input logic [3:0] m,
                        input logic wv, input logic [3:0] we, input logic [3:0] wm,
                        input logic kv, input logic [3:0] ke, input logic [3:0] km);
        bit rdy;
        bit fire;
        issue_valid = iv; srcA = a; srcB = b; destE = e; destM = m;
        wb_valid = wv; wb_destE = we; wb_destM = wm;
        kill_valid = kv; kill_destE = ke; kill_destM = km;
        #1;
        rdy  = m_ready();
        fire = iv && rdy;
        chk({tag, ".ready"}, {31'd0, issue_ready}, {31'd0, rdy});
        @(posedge clk);
        for (int r = 0; r < 15; r++) begin
            int n = cnt_m[r];
            if (fire && hits(r, e, m)) n = n + 1;
            if (wv && hits(r, we, wm)) n = n - 1;
            if (kv && hits(r, ke, km)) n = n - 1;
            if (n < 0) begin
                n = 0;
                err_m = 1'b1;
            end
            cnt_m[r] = n;
        end
        #1;
        chk({tag, ".vec"}, {17'd0, pending_vec}, {17'd0, m_vec()});
        chk({tag, ".err"}, {31'd0, err}, {31'd0, err_m});
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF);
    endtask

    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        for (int r = 0; r < 15; r++) cnt_m[r] = 0;
        err_m = 1'b0;
        chk({tag, ".rst_vec"}, {17'd0, pending_vec}, 32'd0);
        chk({tag, ".rst_err"}, {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int r = 0; r < 15; r++) cnt_m[r] = 0;
        @(negedge clk);
        @(negedge clk);
        chk("reset.vec", {17'd0, pending_vec}, 32'd0);
        chk("reset.err", {31'd0, err}, 32'd0);
        chk("reset.ready", {31'd0, issue_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: issue destE=3, then a reader of r3 is held
        step("t1.issue", 1'b1, 4'hF, 4'hF, 4'd3, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF);
        chk("t1.vec8", {17'd0, pending_vec}, 32'h0008);
        // 2: same-cycle wb does not release the reader; next cycle it does
        step("t2.hold", 1'b1, 4'd3, 4'hF, 4'hF, 4'hF, 1'b1, 4'd3, 4'hF, 1'b0, 4'hF, 4'hF);
        chk("t2.vec0", {17'd0, pending_vec}, 32'h0000);
        step("t2.go", 1'b1, 4'd3, 4'hF, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF);
        chk("t2.ready1", {31'd0, issue_ready}, 32'd1);
        // 3: destE==destM counts once
        step("t3.issue", 1'b1, 4'hF, 4'hF, 4'd5, 4'd5, 1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF);
        step("t3.wb", 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 4'd5, 4'd5, 1'b0, 4'hF, 4'hF);
        chk("t3.vec0", {17'd0, pending_vec}, 32'h0000);
        chk("t3.err0", {31'd0, err}, 32'd0);
        // 4: saturation at 3 blocks issue even with a same-cycle wb
        for (int i = 0; i < 3; i++)
            step("t4.fill", 1'b1, 4'hF, 4'hF, 4'd2, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF);
        chk("t4.cnt3", cnt_m[2], 32'd3);
        step("t4.blocked", 1'b1, 4'hF, 4'hF, 4'd2, 4'hF, 1'b1, 4'd2, 4'hF, 1'b0, 4'hF, 4'hF);
        chk("t4.cnt2", cnt_m[2], 32'd2);
        step("t4.again", 1'b1, 4'hF, 4'hF, 4'd2, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF);
        for (int i = 0; i < 3; i++)
            step("t4.drain", 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 4'd2, 4'hF, 1'b0, 4'hF, 4'hF);
        // 5: issue, wb and kill on r7 together
        for (int i = 0; i < 2; i++)
            step("t5.fill", 1'b1, 4'hF, 4'hF, 4'd7, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF);
        step("t5.all", 1'b1, 4'hF, 4'hF, 4'd7, 4'hF, 1'b1, 4'd7, 4'hF, 1'b1, 4'd7, 4'hF);
        chk("t5.cnt1", cnt_m[7], 32'd1);
        chk("t5.vec", {17'd0, pending_vec}, 32'h0080);
        step("t5.kill", 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b1, 4'd7, 4'hF);
        // 6: underflow is sticky; reset clears at once
        step("t6.uf", 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 4'd9, 4'hF, 1'b0, 4'hF, 4'hF);
        chk("t6.err1", {31'd0, err}, 32'd1);
        idle("t6.sticky");
        step("t6.pend", 1'b1, 4'hF, 4'hF, 4'd4, 4'd14, 1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF);
        do_reset("t6");

        // Random traffic, mostly valid addresses with RNONE mixed in.
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 7) == 0),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if (i == 200) do_reset("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
